// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit seven-segment scan controller with frame-aligned double buffering
// Optional feature macro: SEG_LZ_BLANK_EN (leading-zero blanking)
module seg_scan_ctrl #(
  parameter int DIV  = 25000,
  parameter int DEAD = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  LEDSEL,
  output logic [7:0]  LEDOUT,
  output logic        frame_tick,
  output logic        upd_done
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    dig;
  logic [15:0]   sh_value, pd_value;
  logic [3:0]    sh_dp, pd_dp;
  logic [3:0]    sh_blank, pd_blank;
  logic          pend;

  logic          slot_end;
  logic          boundary;
  logic [3:0]    nib;
  logic [3:0]    lz_dark;
  logic          dark;
  logic [7:0]    glyph;
  logic [3:0]    nxt_sel;
  logic [7:0]    nxt_out;

  function automatic logic [7:0] hex_glyph(input logic [3:0] h);
    case (h)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  assign slot_end = (cnt == CW'(DIV - 1));
  assign boundary = en && slot_end && (dig == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      dig <= 2'd0;
    end else if (!en) begin
      cnt <= '0;
      dig <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      dig <= dig + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A load in the boundary cycle still lands in pending; the old pending moves to shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pd_value <= '0;
      pd_dp    <= '0;
      pd_blank <= '0;
      pend     <= 1'b0;
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
    end else begin
      if (boundary && pend) begin
        sh_value <= pd_value;
        sh_dp    <= pd_dp;
        sh_blank <= pd_blank;
      end
      if (load) begin
        pd_value <= value;
        pd_dp    <= dp_mask;
        pd_blank <= blank_mask;
        pend     <= 1'b1;
      end else if (boundary) begin
        pend     <= 1'b0;
      end
    end
  end

`ifdef SEG_LZ_BLANK_EN
  assign lz_dark = {sh_value[15:12] == 4'h0, sh_value[15:8] == 8'h0, sh_value[15:4] == 12'h0, 1'b0};
`else
  assign lz_dark = 4'b0000;
`endif

  always_comb begin
    nib     = sh_value[{dig, 2'b00} +: 4];
    glyph   = hex_glyph(nib);
    dark    = !en || (cnt < CW'(DEAD)) || sh_blank[dig] || lz_dark[dig];
    nxt_sel = 4'hF;
    nxt_out = 8'hFF;
    if (!dark) begin
      nxt_sel = ~(4'b0001 << dig);
      nxt_out = {glyph[7] & ~sh_dp[dig], glyph[6:0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LEDSEL     <= 4'hF;
      LEDOUT     <= 8'hFF;
      frame_tick <= 1'b0;
      upd_done   <= 1'b0;
    end else begin
      LEDSEL     <= nxt_sel;
      LEDOUT     <= nxt_out;
      frame_tick <= boundary;
      upd_done   <= boundary && pend;
    end
  end

endmodule
